// File: rtl/rx_phase_scan.sv
// RX sampling-phase acquisition: scans all OS offsets, measures BER per phase and locks the best one.
// Optional PHASE_SCAN_RELOCK_EN: windowed BER monitoring in LOCK with automatic rescan (adds o_relock).
module rx_phase_scan #(
  parameter int OS           = 4,
  parameter int NB_OFFSET    = 2,
  parameter int NB_ERR       = 16,
  parameter int SETTLE_BAUDS = 16,
  parameter int WINDOW_BITS  = 1022
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 i_valid,
  input  logic                 i_start,
  input  logic [63:0]          i_errors,
  input  logic [63:0]          i_bits,
  output logic [NB_OFFSET-1:0] o_offset,
  output logic                 o_ber_reset,
  output logic                 o_busy,
  output logic                 o_locked,
  output logic                 o_done,
  output logic [NB_ERR-1:0]    o_best_err
`ifdef PHASE_SCAN_RELOCK_EN
  ,
  output logic                 o_relock
`endif
);

  localparam int                 SETTLE_W = $clog2(SETTLE_BAUDS + 1);
  localparam logic [NB_ERR-1:0]  ERR_MAX  = '1;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    SETTLE,
    MEASURE,
    COMPARE,
    LOCK
  } state_t;

  state_t                 state_q, state_d;
  logic [NB_OFFSET-1:0]   idx_q, idx_d;
  logic [NB_OFFSET-1:0]   best_idx_q, best_idx_d;
  logic [NB_ERR-1:0]      best_err_q, best_err_d;
  logic [NB_ERR-1:0]      err_q, err_d;
  logic [SETTLE_W-1:0]    settle_cnt_q, settle_cnt_d;
  logic                   meas_q, meas_d;
  logic                   done_q, done_d;
  logic                   ber_reset;
  logic                   window_hit;
  logic [NB_ERR-1:0]      err_sat;

  assign window_hit = (i_bits >= 64'(WINDOW_BITS));
  assign err_sat    = (|i_errors[63:NB_ERR]) ? ERR_MAX : i_errors[NB_ERR-1:0];

`ifdef PHASE_SCAN_RELOCK_EN
  logic [NB_ERR+1:0] thr_wide;
  logic [NB_ERR-1:0] relock_thr;
  logic              relock;

  // Relock threshold best_err*2+8, clamped to the error register range.
  assign thr_wide   = {1'b0, best_err_q, 1'b0} + (NB_ERR + 2)'(8);
  assign relock_thr = (thr_wide > (NB_ERR + 2)'(ERR_MAX)) ? ERR_MAX : thr_wide[NB_ERR-1:0];
  assign o_relock   = relock;
`endif

  // NOTE: every variable gets its default before the case so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    best_idx_d   = best_idx_q;
    best_err_d   = best_err_q;
    err_d        = err_q;
    settle_cnt_d = settle_cnt_q;
    meas_d       = meas_q;
    done_d       = 1'b0;
    ber_reset    = 1'b0;
`ifdef PHASE_SCAN_RELOCK_EN
    relock       = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (i_start) begin
          state_d    = CLEAR;
          idx_d      = '0;
          best_idx_d = '0;
          best_err_d = ERR_MAX;
          meas_d     = 1'b0;
        end
      end
      CLEAR: begin
        // Second visit (meas_q set) re-clears ber so the window excludes sync errors.
        ber_reset    = 1'b1;
        settle_cnt_d = '0;
        state_d      = meas_q ? MEASURE : SETTLE;
      end
      SETTLE: begin
        if (i_valid) begin
          if (settle_cnt_q == SETTLE_W'(SETTLE_BAUDS - 1)) begin
            state_d = CLEAR;
            meas_d  = 1'b1;
          end else begin
            settle_cnt_d = settle_cnt_q + SETTLE_W'(1);
          end
        end
      end
      MEASURE: begin
        if (window_hit) begin
          err_d   = err_sat;
          state_d = COMPARE;
        end
      end
      COMPARE: begin
        if (err_q < best_err_q) begin
          best_err_d = err_q;
          best_idx_d = idx_q;
        end
        meas_d = 1'b0;
        if (idx_q == NB_OFFSET'(OS - 1)) begin
          state_d = LOCK;
          done_d  = 1'b1;
        end else begin
          idx_d   = idx_q + NB_OFFSET'(1);
          state_d = CLEAR;
        end
      end
      LOCK: begin
        if (i_start) begin
          state_d    = CLEAR;
          idx_d      = '0;
          best_idx_d = '0;
          best_err_d = ERR_MAX;
          meas_d     = 1'b0;
        end
`ifdef PHASE_SCAN_RELOCK_EN
        else if (window_hit) begin
          ber_reset = 1'b1;
          if (err_sat > relock_thr) begin
            relock     = 1'b1;
            state_d    = CLEAR;
            idx_d      = '0;
            best_idx_d = '0;
            best_err_d = ERR_MAX;
            meas_d     = 1'b0;
          end
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      best_idx_q   <= '0;
      best_err_q   <= ERR_MAX;
      err_q        <= '0;
      settle_cnt_q <= '0;
      meas_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      best_idx_q   <= best_idx_d;
      best_err_q   <= best_err_d;
      err_q        <= err_d;
      settle_cnt_q <= settle_cnt_d;
      meas_q       <= meas_d;
      done_q       <= done_d;
    end
  end

  assign o_ber_reset = ber_reset;
  assign o_busy      = (state_q == CLEAR) || (state_q == SETTLE) ||
                       (state_q == MEASURE) || (state_q == COMPARE);
  assign o_locked    = (state_q == LOCK);
  assign o_done      = done_q;
  assign o_best_err  = (state_q == LOCK) ? best_err_q : '0;
  assign o_offset    = (state_q == LOCK) ? best_idx_q :
                       (state_q == IDLE) ? '0 : idx_q;

endmodule
